// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc measurement responder: state encoding and default widths.
package fproc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fproc_state_e;

    localparam int unsigned FPROC_ID_W   = 8;
    localparam int unsigned FPROC_DATA_W = 32;

    localparam logic [FPROC_DATA_W-1:0] FPROC_TIMEOUT_DATA = '1;

endpackage

// File: rtl/meas_store.sv
// Per-channel measurement bank: one value bit and one valid flag per channel.
module meas_store #(
    parameter int unsigned N_CHAN = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CHAN-1:0] meas_valid,
    input  logic [N_CHAN-1:0] meas_bit,
    input  logic              consume,
    input  logic [IDX_W-1:0]  consume_idx,
    output logic [N_CHAN-1:0] value,
    output logic [N_CHAN-1:0] valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            valid <= '0;
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (meas_valid[k]) begin
                    value[k] <= meas_bit[k];
                end
                // A consumed channel keeps a flag only when an old result was delivered
                // and a fresh one arrived alongside it; a bypassed write stays consumed.
                if (consume && (consume_idx == IDX_W'(k))) begin
                    valid[k] <= valid[k] & meas_valid[k];
                end else if (meas_valid[k]) begin
                    valid[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fproc_meas_responder.sv
// Far end of the fproc request/ready handshake: answers channel requests from the store.
// Optional timeout response is built only when FPROC_TIMEOUT_EN is defined.
module fproc_meas_responder
    import fproc_pkg::*;
#(
    parameter int unsigned N_CHAN  = 8,
    parameter int unsigned ID_W    = FPROC_ID_W,
    parameter int unsigned DATA_W  = FPROC_DATA_W,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fproc_req,
    input  logic [ID_W-1:0]   fproc_id,
    input  logic [N_CHAN-1:0] meas_valid,
    input  logic [N_CHAN-1:0] meas_bit,
    output logic              fproc_ready,
    output logic [DATA_W-1:0] fproc_data,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    fproc_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N_CHAN-1:0] st_value;
    logic [N_CHAN-1:0] st_valid;
    logic              consume;
    logic [IDX_W-1:0]  sel_idx;
    logic              hit;
    logic              hit_bit;
    logic              id_out_of_range;

    meas_store #(
        .N_CHAN (N_CHAN),
        .IDX_W  (IDX_W)
    ) u_meas_store (
        .clk         (clk),
        .reset       (reset),
        .meas_valid  (meas_valid),
        .meas_bit    (meas_bit),
        .consume     (consume),
        .consume_idx (sel_idx),
        .value       (st_value),
        .valid       (st_valid)
    );

    // In IDLE the incoming id is looked up directly so a ready result answers next cycle.
    assign sel_idx         = (state_q == IDLE) ? fproc_id[IDX_W-1:0] : idx_q;
    assign id_out_of_range = 32'(fproc_id) >= N_CHAN;
    assign hit             = st_valid[sel_idx] | meas_valid[sel_idx];
    assign hit_bit         = st_valid[sel_idx] ? st_value[sel_idx] : meas_bit[sel_idx];

`ifdef FPROC_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        data_d  = data_q;
        consume = 1'b0;
`ifdef FPROC_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (fproc_req) begin
                    idx_d = fproc_id[IDX_W-1:0];
                    if (id_out_of_range) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        data_d  = '0;
                    end else if (hit) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        data_d  = {{(DATA_W-1){1'b0}}, hit_bit};
                        consume = 1'b1;
                    end else begin
                        state_d = WAIT;
`ifdef FPROC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (hit) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    data_d  = {{(DATA_W-1){1'b0}}, hit_bit};
                    consume = 1'b1;
`ifdef FPROC_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    data_d  = '1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign fproc_ready = ready_q;
    assign fproc_data  = data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fproc_meas_responder.sv
// Scoreboard bench for fproc_meas_responder; timeout cases run when FPROC_TIMEOUT_EN is defined.
module tb_fproc_meas_responder;

    localparam int unsigned N_CHAN  = 8;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              fproc_req;
    logic [ID_W-1:0]   fproc_id;
    logic [N_CHAN-1:0] meas_valid;
    logic [N_CHAN-1:0] meas_bit;
    logic              fproc_ready;
    logic [DATA_W-1:0] fproc_data;
    logic              busy;
    logic              err;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    fproc_meas_responder #(
        .N_CHAN  (N_CHAN),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fproc_req   (fproc_req),
        .fproc_id    (fproc_id),
        .meas_valid  (meas_valid),
        .meas_bit    (meas_bit),
        .fproc_ready (fproc_ready),
        .fproc_data  (fproc_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest expected response, including its cycle.
    always @(negedge clk) begin
        if (!reset && fproc_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: cyc=%0d data=%h, required no pulse", cyc,
                         fproc_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (fproc_data !== e.data || err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                             fproc_data, err, cyc, e.data, e.err, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        exp_q.push_back(x);
    endtask

    task automatic meas(input int ch, input logic b);
        meas_valid     = '0;
        meas_bit       = '0;
        meas_valid[ch] = 1'b1;
        meas_bit[ch]   = b;
        tick();
        meas_valid = '0;
        meas_bit   = '0;
    endtask

    // Request expected to be answered on the next cycle.
    task automatic req_now(input int id, input logic [DATA_W-1:0] d);
        fproc_req = 1'b1;
        fproc_id  = ID_W'(id);
        push(d, 1'b0, cyc + 1);
        tick();
        fproc_req = 1'b0;
        tick();
    endtask

    // Request on an empty channel: must sit in WAIT; released by a measurement of bit b.
    task automatic req_wait(input string name, input int id, input logic b);
        fproc_req = 1'b1;
        fproc_id  = ID_W'(id);
        tick();
        fproc_req = 1'b0;
        tick();
        @(negedge clk);
        check({name, "_busy"}, DATA_W'(busy), 1);
        check({name, "_no_resp"}, exp_q.size(), 0);
        tick();
        meas_valid[id] = 1'b1;
        meas_bit[id]   = b;
        push({31'd0, b}, 1'b0, cyc + 1);
        tick();
        meas_valid = '0;
        meas_bit   = '0;
        tick();
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        fproc_req  = 1'b0;
        fproc_id   = '0;
        meas_valid = '0;
        meas_bit   = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", DATA_W'(fproc_ready), 0);
        check("rst_data", fproc_data, 0);
        check("rst_busy", DATA_W'(busy), 0);
        check("rst_err", DATA_W'(err), 0);
        tick();
        reset = 1'b0;
        tick();

        // Preloaded result, then the flag must be gone.
        meas(3, 1'b1);
        req_now(3, 32'h1);
        req_wait("ch3_consumed", 3, 1'b0);

        // Waiting request held for 20 cycles.
        fproc_req = 1'b1;
        fproc_id  = 8'd5;
        tick();
        fproc_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("wait5_busy", DATA_W'(busy), 1);
        end
        tick();
        meas_valid[5] = 1'b1;
        push(32'h0, 1'b0, cyc + 1);
        tick();
        meas_valid = '0;
        tick();
        req_wait("ch5_flag_clear", 5, 1'b1);

        // Stored bit delivered while a new bit is written the same cycle.
        meas(2, 1'b1);
        meas_valid[2] = 1'b1;
        meas_bit[2]   = 1'b0;
        req_now(2, 32'h1);
        meas_valid = '0;
        meas_bit   = '0;
        req_now(2, 32'h0);

        // Out-of-range id right after a data=1 response.
        meas(4, 1'b1);
        req_now(4, 32'h1);
        req_now(200, 32'h0);

        // Request during WAIT is ignored even though ch7 holds a result.
        meas(7, 1'b1);
        fproc_req = 1'b1;
        fproc_id  = 8'd6;
        tick();
        fproc_req = 1'b0;
        tick();
        fproc_req = 1'b1;
        fproc_id  = 8'd7;
        tick();
        fproc_req = 1'b0;
        tick();
        @(negedge clk);
        check("ignored_req_busy", DATA_W'(busy), 1);
        tick();
        meas_valid[6] = 1'b1;
        meas_bit[6]   = 1'b1;
        push(32'h1, 1'b0, cyc + 1);
        tick();
        meas_valid = '0;
        meas_bit   = '0;
        tick();
        req_now(7, 32'h1);

        // Reset mid-WAIT clears flags and aborts with no pulse.
        meas(0, 1'b1);
        fproc_req = 1'b1;
        fproc_id  = 8'd1;
        tick();
        fproc_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_wait_busy", DATA_W'(busy), 0);
        check("rst_wait_ready", DATA_W'(fproc_ready), 0);
        tick();
        req_wait("ch0_flag_reset", 0, 1'b0);
        meas(1, 1'b1);
        req_now(1, 32'h1);

`ifdef FPROC_TIMEOUT_EN
        fproc_req = 1'b1;
        fproc_id  = 8'd3;
        push(32'hFFFF_FFFF, 1'b1, cyc + 17);
        tick();
        fproc_req = 1'b0;
        repeat (19) tick();
        n = cyc;
        fproc_req = 1'b1;
        fproc_id  = 8'd3;
        tick();
        fproc_req = 1'b0;
        while (cyc < n + 16) tick();
        meas_valid[3] = 1'b1;
        meas_bit[3]   = 1'b1;
        push(32'h1, 1'b0, cyc + 1);
        tick();
        meas_valid = '0;
        meas_bit   = '0;
        repeat (2) tick();
`else
        n = 0;
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("pending_responses", exp_q.size(), 0);
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
